axi4_lite_slave: RTL and testbench

//  AXI4-Lite subordinate (responder) presenting NUM_REGS memory-mapped registers.

---
 rtl/axi4_lite_pkg.sv | 31 +++
 rtl/axi4_lite_regfile.sv | 59 +++++
 rtl/axi4_lite_slave.sv | 201 ++++++++++++++++++++
 tb/tb_axi4_lite_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
//   Shared types and constants for the AXI4-Lite subordinate register block.
//   - resp_t   : AXI response encoding used on BRESP / RRESP
//   - wstate_t : write-channel FSM states
//   - rstate_t : read-channel FSM states
//   - ADDR_LSB : lowest address bit used for register decode (32-bit words)
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // Registers are word aligned; the two byte-offset bits never select a register.
  localparam int ADDR_LSB = 2;

endpackage : axi4_lite_pkg

// File: rtl/axi4_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi4_lite_regfile
//   NUM_REGS x DATA_WIDTH register array with one byte-strobed write port and
//   one combinational read port. All registers are also exported flat.
// Ports
//   ACLK      in   clock, rising edge
//   ARESET    in   asynchronous active-high reset, clears every register
//   wr_en     in   commit strobe; write happens on the rising edge
//   wr_idx    in   register index to write
//   wr_data   in   write data
//   wr_strb   in   byte enables; byte b written only when wr_strb[b] is set
//   rd_idx    in   register index to read
//   rd_data   out  combinational read of regs[rd_idx] (pre-write value on a
//                  commit edge)
//   regs_out  out  register i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module axi4_lite_regfile #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // NOTE: this array is reset because its contents are visible to software and
  // to the downstream datapath; a plain RAM without reset would read as X.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = regs[rd_idx];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule : axi4_lite_regfile

// File: rtl/axi4_lite_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave
//   AXI4-Lite subordinate exposing NUM_REGS 32-bit registers. Read and write
//   channels are independent, each with one outstanding transaction.
// Parameters
//   ADDRESS     address width in bits
//   DATA_WIDTH  data width in bits (32 in this revision, 4 strobes)
//   NUM_REGS    register count, power of two, >= 2
// Ports
//   ACLK, ARESET                 clock, asynchronous active-high reset
//   S_AW*  / S_W*  / S_B*        write address, write data, write response
//   S_AR*  / S_R*                read address, read data/response
//   regs_out                     register i at [i*32 +: 32]
// Behaviour summary
//   AW and W are latched independently; once both are held the next edge
//   commits the write and raises BVALID. A read is answered one cycle after the
//   AR handshake. Addresses at or above NUM_REGS*4 answer SLVERR and never
//   touch the register array; reads of such addresses return 0.
// -----------------------------------------------------------------------------
module axi4_lite_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  // write address
  input  logic [ADDRESS-1:0]             S_AWADDR,
  input  logic                           S_AWVALID,
  output logic                           S_AWREADY,
  // write data
  input  logic [DATA_WIDTH-1:0]          S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
  input  logic                           S_WVALID,
  output logic                           S_WREADY,
  // write response
  output logic [1:0]                     S_BRESP,
  output logic                           S_BVALID,
  input  logic                           S_BREADY,
  // read address
  input  logic [ADDRESS-1:0]             S_ARADDR,
  input  logic                           S_ARVALID,
  output logic                           S_ARREADY,
  // read data
  output logic [DATA_WIDTH-1:0]          S_RDATA,
  output logic [1:0]                     S_RRESP,
  output logic                           S_RVALID,
  input  logic                           S_RREADY,
  // register export
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;
  // First byte address past the register window.
  localparam logic [ADDRESS-1:0] ADDR_END = ADDRESS'(NUM_REGS * STRB_W);

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  wstate_t               wstate;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDRESS-1:0]    awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_in_range;
  logic                  commit;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;

  assign aw_in_range = (awaddr_q < ADDR_END);
  assign wr_idx      = awaddr_q[ADDR_LSB +: IDX_W];
  // Both halves of the write are latched: this edge performs the update.
  assign commit      = (wstate == W_IDLE) && aw_held && w_held;
  assign wr_en       = commit && aw_in_range;

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  rstate_t               rstate;
  logic                  ar_in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  assign ar_in_range = (S_ARADDR < ADDR_END);
  assign rd_idx      = S_ARADDR[ADDR_LSB +: IDX_W];

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  axi4_lite_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wdata_q),
    .wr_strb  (wstrb_q),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .regs_out (regs_out)
  );

  // ---------------------------------------------------------------------------
  // Write FSM. READY outputs are registered: each drops on the edge that
  // captures its channel and returns on the edge that retires the response.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would make results depend on statement
  // order and mis-simulate against the synthesised netlist.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate    <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      S_AWREADY <= 1'b1;
      S_WREADY  <= 1'b1;
      S_BVALID  <= 1'b0;
      S_BRESP   <= OKAY;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (S_AWVALID && S_AWREADY) begin
            awaddr_q  <= S_AWADDR;
            aw_held   <= 1'b1;
            S_AWREADY <= 1'b0;
          end
          if (S_WVALID && S_WREADY) begin
            wdata_q  <= S_WDATA;
            wstrb_q  <= S_WSTRB;
            w_held   <= 1'b1;
            S_WREADY <= 1'b0;
          end
          // Both READYs are already low here, so no new capture competes.
          if (commit) begin
            S_BVALID <= 1'b1;
            S_BRESP  <= aw_in_range ? OKAY : SLVERR;
            wstate   <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_BREADY) begin
            S_BVALID  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            S_AWREADY <= 1'b1;
            S_WREADY  <= 1'b1;
            wstate    <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM. The read port is combinational, so an AR captured on a commit
  // edge sees the register value from before that write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate    <= R_IDLE;
      S_ARREADY <= 1'b1;
      S_RVALID  <= 1'b0;
      S_RDATA   <= '0;
      S_RRESP   <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_ARVALID && S_ARREADY) begin
            S_RDATA   <= ar_in_range ? rd_data : '0;
            S_RRESP   <= ar_in_range ? OKAY : SLVERR;
            S_RVALID  <= 1'b1;
            S_ARREADY <= 1'b0;
            rstate    <= R_DATA;
          end
        end
        R_DATA: begin
          // RDATA/RRESP are left untouched so they stay stable under back-pressure.
          if (S_RREADY) begin
            S_RVALID  <= 1'b0;
            S_ARREADY <= 1'b1;
            rstate    <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule : axi4_lite_slave

// File: tb/tb_axi4_lite_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_slave
//   Directed bench for axi4_lite_slave (NUM_REGS = 8). Stimulus pushes the
//   expected B / R responses into queues; a negedge monitor pops and compares
//   whenever a response handshake is about to happen. Timing-specific points
//   (READY drops, latency, stability, reset) are checked inline.
// -----------------------------------------------------------------------------
module tb_axi4_lite_slave;

  localparam int ADDRESS    = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic                           ACLK;
  logic                           ARESET;
  logic [ADDRESS-1:0]             S_AWADDR;
  logic                           S_AWVALID;
  logic                           S_AWREADY;
  logic [DATA_WIDTH-1:0]          S_WDATA;
  logic [3:0]                     S_WSTRB;
  logic                           S_WVALID;
  logic                           S_WREADY;
  logic [1:0]                     S_BRESP;
  logic                           S_BVALID;
  logic                           S_BREADY;
  logic [ADDRESS-1:0]             S_ARADDR;
  logic                           S_ARVALID;
  logic                           S_ARREADY;
  logic [DATA_WIDTH-1:0]          S_RDATA;
  logic [1:0]                     S_RRESP;
  logic                           S_RVALID;
  logic                           S_RREADY;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_out;

  axi4_lite_slave #(
    .ADDRESS    (ADDRESS),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .S_AWADDR  (S_AWADDR),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_WDATA   (S_WDATA),
    .S_WSTRB   (S_WSTRB),
    .S_WVALID  (S_WVALID),
    .S_WREADY  (S_WREADY),
    .S_BRESP   (S_BRESP),
    .S_BVALID  (S_BVALID),
    .S_BREADY  (S_BREADY),
    .S_ARADDR  (S_ARADDR),
    .S_ARVALID (S_ARVALID),
    .S_ARREADY (S_ARREADY),
    .S_RDATA   (S_RDATA),
    .S_RRESP   (S_RRESP),
    .S_RVALID  (S_RVALID),
    .S_RREADY  (S_RREADY),
    .regs_out  (regs_out)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int          total = 0;
  int          bad   = 0;
  int          b_hs  = 0;
  logic [1:0]  b_exp [$];
  rexp_t       r_exp [$];
  logic [31:0] exp_regs [NUM_REGS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: a response is consumed on the next rising edge whenever VALID and
  // READY are both high at the preceding falling edge.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (S_BVALID && S_BREADY) begin
        b_hs++;
        if (b_exp.size() == 0) fail_now("b_unexpected");
        else check("bresp", 32'(S_BRESP), 32'(b_exp.pop_front()));
      end
      if (S_RVALID && S_RREADY) begin
        if (r_exp.size() == 0) begin
          fail_now("r_unexpected");
        end else begin
          rexp_t e;
          e = r_exp.pop_front();
          check("rresp", 32'(S_RRESP), 32'(e.resp));
          check("rdata", S_RDATA, e.data);
        end
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] r);
    logic aw_acc, w_acc;
    b_exp.push_back(r);
    S_AWADDR  = a;
    S_WDATA   = d;
    S_WSTRB   = s;
    S_AWVALID = 1'b1;
    S_WVALID  = 1'b1;
    for (int i = 0; i < 50 && (S_AWVALID || S_WVALID); i++) begin
      @(negedge ACLK);
      aw_acc = S_AWVALID && S_AWREADY;
      w_acc  = S_WVALID && S_WREADY;
      @(posedge ACLK);
      #1;
      if (aw_acc) S_AWVALID = 1'b0;
      if (w_acc)  S_WVALID  = 1'b0;
    end
    if (S_AWVALID || S_WVALID) begin
      fail_now("write_accept_timeout");
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b0;
    end
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [1:0] r, input logic [31:0] d);
    logic acc;
    r_exp.push_back('{resp: r, data: d});
    S_ARADDR  = a;
    S_ARVALID = 1'b1;
    for (int i = 0; i < 50 && S_ARVALID; i++) begin
      @(negedge ACLK);
      acc = S_ARREADY;
      @(posedge ACLK);
      #1;
      if (acc) S_ARVALID = 1'b0;
    end
    if (S_ARVALID) begin
      fail_now("read_accept_timeout");
      S_ARVALID = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((b_exp.size() != 0 || r_exp.size() != 0 || S_BVALID || S_RVALID) && n < 50) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    if (n >= 50) fail_now("drain_timeout");
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      check($sformatf("%s_reg%0d", tag, i), regs_out[i*32 +: 32], exp_regs[i]);
    end
  endtask

  initial begin
    int b0;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 32'h0;
    ARESET    = 1'b1;
    S_AWADDR  = '0;
    S_AWVALID = 1'b0;
    S_WDATA   = '0;
    S_WSTRB   = '0;
    S_WVALID  = 1'b0;
    S_BREADY  = 1'b1;
    S_ARADDR  = '0;
    S_ARVALID = 1'b0;
    S_RREADY  = 1'b1;

    // ---- reset state ----
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_awready", 32'(S_AWREADY), 32'd1);
    check("rst_wready",  32'(S_WREADY),  32'd1);
    check("rst_arready", 32'(S_ARREADY), 32'd1);
    check("rst_bvalid",  32'(S_BVALID),  32'd0);
    check("rst_rvalid",  32'(S_RVALID),  32'd0);
    check("rst_bresp",   32'(S_BRESP),   32'd0);
    check("rst_rresp",   32'(S_RRESP),   32'd0);
    check("rst_rdata",   S_RDATA,        32'h0);
    check_regs("rst");
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // ---- 1: AW and W in the same cycle ----
    b0 = b_hs;
    b_exp.push_back(2'b00);
    S_AWADDR = 32'h04; S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    @(posedge ACLK); #1;               // capture edge
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    check("t1_awready_low", 32'(S_AWREADY), 32'd0);
    check("t1_wready_low",  32'(S_WREADY),  32'd0);
    check("t1_bvalid_early", 32'(S_BVALID), 32'd0);
    @(posedge ACLK); #1;               // commit edge
    check("t1_bvalid", 32'(S_BVALID), 32'd1);
    check("t1_reg1", regs_out[63:32], 32'hDEADBEEF);
    @(posedge ACLK); #1;               // B handshake
    check("t1_bvalid_clr", 32'(S_BVALID), 32'd0);
    check("t1_awready_back", 32'(S_AWREADY), 32'd1);
    check("t1_wready_back",  32'(S_WREADY),  32'd1);
    check("t1_b_count", 32'(b_hs - b0), 32'd1);
    exp_regs[1] = 32'hDEADBEEF;

    // ---- 2: W first, AW three cycles later, partial strobes ----
    b0 = b_hs;
    b_exp.push_back(2'b00);
    S_WDATA = 32'h11223344; S_WSTRB = 4'b0101; S_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_wait",  32'(S_WREADY),  32'd0);
      check("t2_awready_wait", 32'(S_AWREADY), 32'd1);
      check("t2_bvalid_wait",  32'(S_BVALID),  32'd0);
      @(posedge ACLK); #1;
    end
    S_AWADDR = 32'h08; S_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0;
    check("t2_bvalid_early", 32'(S_BVALID), 32'd0);
    @(posedge ACLK); #1;
    check("t2_bvalid", 32'(S_BVALID), 32'd1);
    check("t2_reg2", regs_out[95:64], 32'h00220044);
    repeat (4) @(posedge ACLK);
    #1;
    check("t2_b_count", 32'(b_hs - b0), 32'd1);
    exp_regs[2] = 32'h00220044;

    // ---- 3: read with RREADY held low for 4 cycles ----
    S_RREADY = 1'b0;
    r_exp.push_back('{resp: 2'b00, data: 32'hDEADBEEF});
    S_ARADDR = 32'h04; S_ARVALID = 1'b1;
    @(posedge ACLK); #1;               // AR handshake
    S_ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t3_rvalid_hold",  32'(S_RVALID),  32'd1);
      check("t3_rdata_hold",   S_RDATA,        32'hDEADBEEF);
      check("t3_arready_low",  32'(S_ARREADY), 32'd0);
      @(posedge ACLK); #1;
    end
    S_RREADY = 1'b1;
    @(posedge ACLK); #1;
    check("t3_rvalid_clr",   32'(S_RVALID),  32'd0);
    check("t3_arready_back", 32'(S_ARREADY), 32'd1);

    // ---- 4: out-of-range write and read; first invalid address ----
    write_txn(32'h40, 32'hFFFFFFFF, 4'hF, 2'b10);
    drain();
    write_txn(32'h20, 32'h55555555, 4'hF, 2'b10);
    drain();
    check_regs("t4");
    read_txn(32'h40, 2'b10, 32'h0);
    drain();

    // ---- extra directed patterns ----
    write_txn(32'h1C, 32'hA5A5_0F0F, 4'hF, 2'b00);   // highest register
    drain();
    exp_regs[7] = 32'hA5A50F0F;
    write_txn(32'h08, 32'hAABBCCDD, 4'b1000, 2'b00); // top byte only
    drain();
    exp_regs[2] = 32'hAA220044;
    write_txn(32'h04, 32'h01234567, 4'b0000, 2'b00); // no strobes
    drain();
    check_regs("strb");
    read_txn(32'h07, 2'b00, 32'hDEADBEEF);           // byte offset ignored
    read_txn(32'h08, 2'b00, 32'hAA220044);
    read_txn(32'h1C, 2'b00, 32'hA5A50F0F);
    drain();

    // ---- 5: AR captured on the commit edge returns pre-write value ----
    write_txn(32'h0C, 32'h12345678, 4'hF, 2'b00);
    drain();
    b_exp.push_back(2'b00);
    r_exp.push_back('{resp: 2'b00, data: 32'h12345678});
    S_AWADDR = 32'h0C; S_WDATA = 32'hCAFEF00D; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    @(posedge ACLK); #1;               // capture edge
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    check("t5_awready_low", 32'(S_AWREADY), 32'd0);
    S_ARADDR = 32'h0C; S_ARVALID = 1'b1;
    @(posedge ACLK); #1;               // commit edge + AR handshake
    S_ARVALID = 1'b0;
    check("t5_bvalid", 32'(S_BVALID), 32'd1);
    check("t5_rvalid", 32'(S_RVALID), 32'd1);
    drain();
    read_txn(32'h0C, 2'b00, 32'hCAFEF00D);
    drain();
    exp_regs[3] = 32'hCAFEF00D;
    check_regs("t5");

    // ---- 6: reset while both responses are pending ----
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    S_AWADDR = 32'h04; S_WDATA = 32'h00000001; S_WSTRB = 4'hF;
    S_ARADDR = 32'h04;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    @(posedge ACLK); #1;
    check("t6_bvalid_pend", 32'(S_BVALID), 32'd1);
    check("t6_rvalid_pend", 32'(S_RVALID), 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    check("t6_bvalid_drop", 32'(S_BVALID), 32'd0);
    check("t6_rvalid_drop", 32'(S_RVALID), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 32'h0;
    check_regs("t6");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("t6_awready", 32'(S_AWREADY), 32'd1);
    check("t6_wready",  32'(S_WREADY),  32'd1);
    check("t6_arready", 32'(S_ARREADY), 32'd1);
    check("t6_bvalid",  32'(S_BVALID),  32'd0);
    S_BREADY = 1'b1; S_RREADY = 1'b1;
    read_txn(32'h04, 2'b00, 32'h0);
    drain();

    check("b_queue_empty", 32'(b_exp.size()), 32'd0);
    check("r_queue_empty", 32'(r_exp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axi4_lite_slave
